// File: rtl/store_write_buffer.sv
// store_write_buffer: posted-write FIFO between the core store path and the
// data memory write port. Stores are accepted in one cycle, drained in order
// one word per cycle while the memory port is free, and loads forward from the
// youngest matching pending store.

// Per-entry forwarding comparator: one instance per buffer slot.
module swb_entry_match #(
   parameter int IDX_W = 6
) (
   input  logic             valid,
   input  logic [IDX_W-1:0] entry_idx,
   input  logic [IDX_W-1:0] ld_idx,
   output logic             hit
);
   // Match on the memory word index only, so aliasing mirrors the memory.
   assign hit = valid && (entry_idx == ld_idx);
endmodule

module store_write_buffer #(
   parameter int DEPTH = 4,
   parameter int IDX_W = 6
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     st_valid,
   input  logic [31:0]              st_addr,
   input  logic [31:0]              st_data,
   output logic                     st_ready,
   input  logic [31:0]              ld_addr,
   output logic                     ld_hit,
   output logic [31:0]              ld_data,
   input  logic                     mem_busy,
   output logic                     mem_we,
   output logic [31:0]              mem_addr,
   output logic [31:0]              mem_wdata,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]  head_q, tail_q;
   logic [CNT_W-1:0]  count_q;
   logic [DEPTH-1:0]  ent_valid_q;
   logic [31:0]       ent_addr_q [DEPTH];
   logic [31:0]       ent_data_q [DEPTH];
   logic [DEPTH-1:0]  hit_vec;
   logic              push, drain;
   logic              unused_ld;

   // Only the word-index bits of the load address take part in forwarding.
   assign unused_ld = ^{ld_addr[31:IDX_W+2], ld_addr[1:0]};

   assign empty    = (count_q == '0);
   assign count    = count_q;
   // Full blocks a push even when a drain frees a slot on the same edge.
   assign st_ready = (count_q != CNT_W'(DEPTH));
   assign push     = st_valid && st_ready;
   assign drain    = mem_we;

   // Write port: head entry, zeroed when idle or in reset so nothing stale leaks.
   assign mem_we    = !reset && !empty && !mem_busy;
   assign mem_addr  = (reset || empty) ? 32'd0 : ent_addr_q[head_q];
   assign mem_wdata = (reset || empty) ? 32'd0 : ent_data_q[head_q];

   // One comparator per slot against the load's word index.
   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : g_match
         swb_entry_match #(.IDX_W(IDX_W)) u_match (
            .valid     (ent_valid_q[g]),
            .entry_idx (ent_addr_q[g][IDX_W+1:2]),
            .ld_idx    (ld_addr[IDX_W+1:2]),
            .hit       (hit_vec[g])
         );
      end
   endgenerate

   // Scan from oldest to youngest; the last match seen is the youngest store.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx     = '0;
      ld_hit  = 1'b0;
      ld_data = 32'd0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + PTR_W'(k);
         if (hit_vec[idx]) begin
            ld_hit  = 1'b1;
            ld_data = ent_data_q[idx];
         end
      end
   end

   // Pointers, occupancy and valid bits; reset discards all pending stores.
   always_ff @(posedge clock) begin
      if (reset) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         ent_valid_q <= '0;
      end else begin
         if (drain) begin
            ent_valid_q[head_q] <= 1'b0;
            head_q              <= head_q + 1'b1;
         end
         if (push) begin
            ent_valid_q[tail_q] <= 1'b1;
            tail_q              <= tail_q + 1'b1;
         end
         count_q <= count_q + CNT_W'(push) - CNT_W'(drain);
      end
   end

   // Entry payload; qualified by the valid bits, so it needs no reset.
   always_ff @(posedge clock) begin
      if (push) begin
         ent_addr_q[tail_q] <= st_addr;
         ent_data_q[tail_q] <= st_data;
      end
   end
endmodule

// File: doc/store_write_buffer.md
# store_write_buffer

Posted-write buffer between the single-cycle core's store path and the 64-word data memory. Stores are accepted in one cycle and queued in a small FIFO. The queue drains one word per cycle into the memory write port whenever that port is not busy. Loads search the queue combinationally, so the core always sees its own latest pending store.

## Interface
- DEPTH, 4, number of buffer entries; power of two, ≥2
- IDX_W, 6, word-index width; matches memory indexing on addr[IDX_W+1:2]
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- st_valid  in  1  core presents a store this cycle
- st_addr  in  32  store byte address; bits [1:0] ignored
- st_data  in  32  store word
- st_ready  out  1  buffer can accept a store this cycle
- ld_addr  in  32  current load byte address
- ld_hit  out  1  a pending store matches ld_addr's word index
- ld_data  out  32  data of youngest matching pending store; 0 when no hit
- mem_busy  in  1  memory write port unavailable this cycle
- mem_we  out  1  write enable to data memory
- mem_addr  out  32  write address to data memory
- mem_wdata  out  32  write data to data memory
- empty  out  1  no pending stores
- count  out  clog2(DEPTH)+1  number of pending stores

## Operation
- Storage is a circular FIFO with head (oldest) pointer, tail pointer, and count.
- Entry fields are the full 32-bit address, data, and valid.
- Push: occurs when st_valid && st_ready, registered at the clock edge into tail.
  - tail advances modulo DEPTH.
- st_ready = (count != DEPTH).
  - No push while full, even if a drain occurs in the same cycle.
- Drain: mem_we = !reset && !empty && !mem_busy.
  - mem_addr and mem_wdata are the head entry's fields, driven combinationally.
  - All three mem outputs are forced to 0 when empty.
- On an edge where mem_we=1, the head entry is invalidated and head advances modulo DEPTH.
- Simultaneous push and drain leave count unchanged; both pointers advance.
- No bypass: a store accepted while empty reaches memory no earlier than the next cycle.
- Stores drain strictly in acceptance order.
- No coalescing: two stores to the same word occupy two entries and both are written.
- Forwarding: compare ld_addr[IDX_W+1:2] against every valid entry's addr[IDX_W+1:2].
  - The comparison uses the same index bits as the memory, so aliasing matches memory behaviour.
  - ld_hit=1 if any entry matches.
  - ld_data comes from the youngest matching entry (closest to tail-1, scanning backward to head).
- The head entry being drained this cycle still participates in forwarding.
  - It remains valid until the edge.
- A store accepted in the current cycle is not visible to forwarding until after the edge.
- count range is 0..DEPTH. empty = (count==0).
- Reset: all entries invalid; head, tail and count are 0; no memory write in any cycle with reset high.
  - Reset mid-operation discards pending stores; no partial drain.
- Reset values: st_ready=1, ld_hit=0, ld_data=0, mem_we=0, mem_addr=0, mem_wdata=0, empty=1, count=0.

## Timing
- Store accept to mem_we asserted: 1 cycle minimum; longer when queued behind older entries or while mem_busy=1.
- Sustained throughput is 1 store per cycle when mem_busy=0.
- Forwarding path (ld_addr to ld_hit/ld_data) is purely combinational, within the same cycle.
- The mem_busy to mem_we path is combinational; mem_busy must be stable before the edge.
- Pointer wrap: head or tail at DEPTH-1 goes to 0 on advance.

## Test plan
- Reset then idle -> st_ready=1, empty=1, count=0, mem_we=0 for 10 cycles.
- Single store addr=0x10, data=0xDEADBEEF, mem_busy=0:
  - next cycle: mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF.
  - following cycle: empty=1.
- mem_busy=1, push 4 stores (0x0/1, 0x4/2, 0x8/3, 0xC/4):
  - count=4, st_ready=0; a fifth st_valid is not accepted.
  - release mem_busy: writes 1,2,3,4 occur in order over 4 cycles; count returns to 0.
- Forwarding with mem_busy=1:
  - push 0x20/0xA, then 0x20/0xB.
  - ld_addr=0x20 -> ld_hit=1, ld_data=0xB.
  - ld_addr=0x120 aliases index 8 -> ld_hit=1, ld_data=0xB.
  - ld_addr=0x24 -> ld_hit=0, ld_data=0.
- Continuous push 10 stores with mem_busy=0:
  - count stays at 1 after the first cycle; pointers wrap past DEPTH-1.
  - memory receives all 10 in order.
- Push 3 stores with mem_busy=1, assert reset for 1 cycle:
  - mem_we=0 during reset; afterwards count=0, empty=1, ld_hit=0; no write of the discarded stores ever occurs.
